// File: rtl/adc_scan_scheduler.sv
// Scan scheduler: ticks at a programmable period, walks the enabled channels
// through one ADC reader, and streams tagged results out through a small FIFO.
module adc_scan_scheduler #(
    parameter int NUM_CH     = 4,
    parameter int CH_W       = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [31:0]       sample_period,
    input  logic [NUM_CH-1:0] ch_mask,
    output logic              conv_start,
    output logic [CH_W-1:0]   conv_ch,
    input  logic              conv_done,
    input  logic [15:0]       conv_data,
    output logic [15:0]       m_axis_tdata,
    output logic [CH_W-1:0]   m_axis_tuser,
    output logic              m_axis_tlast,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [7:0]        drop_count,
    output logic [7:0]        skip_count,
    output logic              timeout_flag
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef struct packed {
        logic [CH_W-1:0] ch;
        logic            last;
        logic [15:0]     data;
    } entry_t;

    typedef enum logic [2:0] {IDLE, SCAN_SEL, START, WAIT_DONE, NEXT} state_t;

    state_t state, state_n;

    logic [31:0]       eff_period, per_cnt;
    logic              tick_q, tick;
    logic [NUM_CH-1:0] scan_mask, mask_left;
    logic [CH_W-1:0]   cur_ch, lo_ch, hi_ch;
    logic [TW-1:0]     tcnt;
    logic              tmo_hit;

    entry_t            mem [FIFO_DEPTH];
    entry_t            head;
    logic [AW:0]       wr_ptr, rd_ptr;
    logic              empty, full, push_req, push_ok, pop;

    // Tick is registered so the first one lands exactly eff_period cycles
    // after the first enabled cycle; gating with enable kills a stale pulse.
    assign eff_period = (sample_period < 32'd2) ? 32'd2 : sample_period;
    assign tick       = tick_q && enable;

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            per_cnt <= '0;
            tick_q  <= 1'b0;
        end else if (per_cnt >= eff_period - 32'd1) begin
            per_cnt <= '0;
            tick_q  <= 1'b1;
        end else begin
            per_cnt <= per_cnt + 32'd1;
            tick_q  <= 1'b0;
        end
    end

    always_comb begin
        lo_ch = '0;
        hi_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (scan_mask[i]) lo_ch = CH_W'(i);
        for (int i = 0; i < NUM_CH; i++)
            if (scan_mask[i]) hi_ch = CH_W'(i);
    end

    assign mask_left = scan_mask & ~(NUM_CH'(1) << cur_ch);
    assign tmo_hit   = (tcnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:      if (tick && ch_mask != '0) state_n = SCAN_SEL;
            SCAN_SEL:  state_n = START;
            START:     state_n = WAIT_DONE;
            WAIT_DONE: if (conv_done || tmo_hit) state_n = NEXT;
            NEXT:      state_n = (mask_left == '0 || !enable) ? IDLE : SCAN_SEL;
            default:   state_n = IDLE;
        endcase
    end

    always_comb begin
        conv_start = (state == START);
    end

    assign conv_ch = cur_ch;

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_mask    <= '0;
            cur_ch       <= '0;
            tcnt         <= '0;
            timeout_flag <= 1'b0;
            skip_count   <= '0;
        end else begin
            case (state)
                IDLE:      if (tick && ch_mask != '0) scan_mask <= ch_mask;
                SCAN_SEL:  cur_ch <= lo_ch;
                START:     tcnt <= '0;
                WAIT_DONE: if (!conv_done) begin
                    if (tmo_hit) timeout_flag <= 1'b1;
                    else         tcnt <= tcnt + TW'(1);
                end
                NEXT:      scan_mask <= mask_left;
                default:   ;
            endcase
            if (tick && state != IDLE && skip_count != 8'hFF)
                skip_count <= skip_count + 8'd1;
        end
    end

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push_req = (state == WAIT_DONE) && conv_done;
    assign pop      = !empty && m_axis_tready;
    assign push_ok  = push_req && (!full || pop);

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr[AW-1:0]] <= '{ch: cur_ch, last: (cur_ch == hi_ch), data: conv_data};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            drop_count <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push_req && !push_ok && drop_count != 8'hFF)
                drop_count <= drop_count + 8'd1;
        end
    end

    assign head          = mem[rd_ptr[AW-1:0]];
    assign m_axis_tvalid = !empty;
    assign m_axis_tdata  = m_axis_tvalid ? head.data : '0;
    assign m_axis_tuser  = m_axis_tvalid ? head.ch   : '0;
    assign m_axis_tlast  = m_axis_tvalid && head.last;

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Directed bench for adc_scan_scheduler with a 20-cycle behavioural ADC reader.
module tb_adc_scan_scheduler;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [31:0] sample_period = 32'd100;
    logic [3:0]  ch_mask = 4'b0000;
    logic        conv_start;
    logic [1:0]  conv_ch;
    logic        conv_done = 1'b0;
    logic [15:0] conv_data = 16'h0;
    logic [15:0] m_axis_tdata;
    logic [1:0]  m_axis_tuser;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic [7:0]  drop_count;
    logic [7:0]  skip_count;
    logic        timeout_flag;

    adc_scan_scheduler #(.NUM_CH(4), .CH_W(2), .FIFO_DEPTH(4), .TIMEOUT(1024)) dut (
        .clk(clk), .reset(reset), .enable(enable), .sample_period(sample_period),
        .ch_mask(ch_mask), .conv_start(conv_start), .conv_ch(conv_ch),
        .conv_done(conv_done), .conv_data(conv_data),
        .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
        .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .drop_count(drop_count),
        .skip_count(skip_count), .timeout_flag(timeout_flag)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // Reader model: answers 20 cycles after conv_start unless the channel is muted.
    logic [3:0] mute = 4'b0000;
    int         rd_busy = 0;
    int         rd_dly = 0;
    logic [1:0] rd_ch = 2'd0;
    always @(negedge clk) begin
        conv_done = 1'b0;
        if (reset) rd_busy = 0;
        else if (rd_busy != 0) begin
            if (rd_dly == 1) begin
                rd_busy = 0;
                if (!mute[rd_ch]) begin
                    conv_done = 1'b1;
                    conv_data = 16'hA000 + 16'(rd_ch);
                end
            end else rd_dly = rd_dly - 1;
        end
        if (!reset && conv_start) begin
            rd_busy = 1;
            rd_dly  = 20;
            rd_ch   = conv_ch;
        end
    end

    int         starts[$];
    logic [1:0] sc[$];
    int         oc[$];
    logic [15:0] od[$];
    logic [1:0] ou[$];
    logic       ol[$];
    always @(negedge clk) begin
        if (!reset) begin
            if (conv_start) begin
                starts.push_back(cyc);
                sc.push_back(conv_ch);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                oc.push_back(cyc);
                od.push_back(m_axis_tdata);
                ou.push_back(m_axis_tuser);
                ol.push_back(m_axis_tlast);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        starts.delete(); sc.delete(); oc.delete();
        od.delete(); ou.delete(); ol.delete();
    endtask

    task automatic start_fresh();
        enable = 1'b0;
        reset  = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        clear_logs();
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) begin
            @(posedge clk); #2;
        end
    endtask

    task automatic wait_out(input int n, input int budget, input string tag);
        int t = 0;
        while (od.size() < n && t < budget) begin
            @(posedge clk); #2; t++;
        end
        check(tag, 32'(od.size()), 32'(n));
    endtask

    task automatic wait_starts(input int n, input int budget, input string tag);
        int t = 0;
        while (starts.size() < n && t < budget) begin
            @(posedge clk); #2; t++;
        end
        check(tag, 32'(starts.size()), 32'(n));
    endtask

    int k, s, r;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check("rst_tvalid",  32'(m_axis_tvalid), 32'd0);
        check("rst_start",   32'(conv_start),    32'd0);
        check("rst_tdata",   32'(m_axis_tdata),  32'd0);
        check("rst_drop",    32'(drop_count),    32'd0);
        check("rst_skip",    32'(skip_count),    32'd0);
        check("rst_timeout", 32'(timeout_flag),  32'd0);

        // Basic scans: mask 1011, period 100, tready high
        ch_mask = 4'b1011; sample_period = 32'd100; m_axis_tready = 1'b1;
        start_fresh();
        enable = 1'b1; k = cyc;
        wait_out(6, 320, "t1_nout");
        check("t1_first_start", 32'(starts[0]), 32'(k + 102));
        check("t1_scan_gap",    32'(starts[3] - starts[0]), 32'd100);
        check("t1_ch_seq",      {26'd0, sc[0], sc[1], sc[2]}, {26'd0, 2'd0, 2'd1, 2'd3});
        check("t1_lat",         32'(oc[0]), 32'(starts[0] + 21));
        check("t1_d0", 32'(od[0]), 32'hA000);
        check("t1_d1", 32'(od[1]), 32'hA001);
        check("t1_d2", 32'(od[2]), 32'hA003);
        check("t1_d3", 32'(od[3]), 32'hA000);
        check("t1_user", {20'd0, ou[0], ou[1], ou[2], ou[3], ou[4], ou[5]},
                         {20'd0, 2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3});
        check("t1_last", {26'd0, ol[0], ol[1], ol[2], ol[3], ol[4], ol[5]}, 32'b000_001_001);
        check("t1_skip", 32'(skip_count), 32'd0);
        enable = 1'b0;

        // Period shorter than a scan: overlapping ticks are skipped
        sample_period = 32'd30;
        start_fresh();
        enable = 1'b1; k = cyc;
        wait_out(6, 260, "t2_nout");
        enable = 1'b0;
        check("t2_skip",     32'(skip_count), 32'd4);
        check("t2_starts",   32'(starts.size()), 32'd6);
        check("t2_scan_gap", 32'(starts[3] - starts[0]), 32'd90);
        check("t2_last", {26'd0, ol[0], ol[1], ol[2], ol[3], ol[4], ol[5]}, 32'b000_001_001);
        check("t2_d5",   32'(od[5]), 32'hA003);

        // Backpressure: 3 scans into a 4-deep FIFO
        sample_period = 32'd100; m_axis_tready = 1'b0;
        start_fresh();
        enable = 1'b1; k = cyc;
        wait_until(k + 380);
        enable = 1'b0;
        check("t3_drop",   32'(drop_count),    32'd5);
        check("t3_tvalid", 32'(m_axis_tvalid), 32'd1);
        check("t3_hold_d", 32'(m_axis_tdata),  32'hA000);
        check("t3_hold_u", 32'(m_axis_tuser),  32'd0);
        check("t3_none",   32'(od.size()),     32'd0);
        m_axis_tready = 1'b1;
        repeat (8) begin @(posedge clk); #2; end
        check("t3_nout", 32'(od.size()), 32'd4);
        check("t3_data", {od[0], od[1]}, {16'hA000, 16'hA001});
        check("t3_data2", {od[2], od[3]}, {16'hA003, 16'hA000});
        check("t3_user", {24'd0, ou[0], ou[1], ou[2], ou[3]}, {24'd0, 2'd0, 2'd1, 2'd3, 2'd0});
        check("t3_last", {28'd0, ol[0], ol[1], ol[2], ol[3]}, 32'b0010);
        check("t3_empty", 32'(m_axis_tvalid), 32'd0);

        // Timeout on ch1 of mask 0011
        ch_mask = 4'b0011; sample_period = 32'd1200; mute = 4'b0010;
        start_fresh();
        enable = 1'b1; k = cyc;
        wait_starts(2, 1300, "t4_two_starts");
        s = starts[1];
        wait_until(s + 1020);
        check("t4_flag_early", 32'(timeout_flag), 32'd0);
        wait_until(s + 1026);
        check("t4_flag_set",   32'(timeout_flag), 32'd1);
        wait_starts(3, 300, "t4_next_scan");
        check("t4_scan_gap", 32'(starts[2] - starts[0]), 32'd1200);
        check("t4_next_ch",  32'(sc[2]), 32'd0);
        check("t4_nout",     32'(od.size()), 32'd1);
        check("t4_d0",       32'(od[0]), 32'hA000);
        check("t4_last0",    32'(ol[0]), 32'd0);
        check("t4_skip",     32'(skip_count), 32'd0);
        enable = 1'b0; mute = 4'b0000;

        // Enable dropped while waiting on ch0, then an empty mask
        ch_mask = 4'b1111; sample_period = 32'd100;
        start_fresh();
        enable = 1'b1;
        wait_starts(1, 200, "t5_start");
        s = starts[0];
        wait_until(s + 5);
        enable = 1'b0;
        wait_until(s + 100);
        check("t5_starts", 32'(starts.size()), 32'd1);
        check("t5_nout",   32'(od.size()), 32'd1);
        check("t5_d0",     32'(od[0]), 32'hA000);
        check("t5_last",   32'(ol[0]), 32'd0);
        ch_mask = 4'b0000; sample_period = 32'd10; enable = 1'b1;
        repeat (100) begin @(posedge clk); #2; end
        check("t5_nomask_starts", 32'(starts.size()), 32'd1);
        check("t5_nomask_skip",   32'(skip_count), 32'd0);
        enable = 1'b0;

        // Reset with 2 entries queued and ch2 in flight
        ch_mask = 4'b0111; sample_period = 32'd100; m_axis_tready = 1'b0;
        start_fresh();
        enable = 1'b1;
        wait_starts(3, 300, "t6_starts");
        s = starts[2];
        wait_until(s + 3);
        check("t6_pre_tvalid", 32'(m_axis_tvalid), 32'd1);
        reset = 1'b1;
        @(posedge clk); #2;
        check("t6_tvalid",  32'(m_axis_tvalid), 32'd0);
        check("t6_start",   32'(conv_start),    32'd0);
        check("t6_drop",    32'(drop_count),    32'd0);
        check("t6_skip",    32'(skip_count),    32'd0);
        check("t6_timeout", 32'(timeout_flag),  32'd0);
        reset = 1'b0; r = cyc;
        clear_logs();
        wait_starts(1, 200, "t6_restart");
        check("t6_restart_at", 32'(starts[0]), 32'(r + 102));
        check("t6_no_stale", 32'(m_axis_tvalid), 32'd0);
        enable = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/adc_scan_scheduler.md
Name: adc_scan_scheduler

Overview:
Controller that sequences a single SPI ADC reader core across multiple input channels at a programmable sample rate. Each tick it issues one conversion request per enabled channel and collects the results. Results are tagged with channel number and end-of-scan, buffered in a small FIFO, and presented on an AXI4-Stream master with full tready backpressure. Sits between the register/config logic and the ADC serial reader, feeding the DMA/stream fabric.

Parameters:
NUM_CH, 4, number of ADC channels; 1..16.
CH_W, 2, channel index width; must be at least clog2(NUM_CH), minimum 1.
FIFO_DEPTH, 4, result FIFO entries; power of two, at least 2.
TIMEOUT, 1024, clk cycles allowed between conv_start and conv_done.

Ports:
clk  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
enable  in  1  scan enable; level.
sample_period  in  32  clk cycles between scan ticks; values below 2 are treated as 2.
ch_mask  in  NUM_CH  enabled channels; bit i enables channel i.
conv_start  out  1  one-cycle request to the reader core.
conv_ch  out  CH_W  channel for the current request; held stable from conv_start until conv_done or timeout.
conv_done  in  1  one-cycle pulse from the reader; conv_data is valid in the same cycle.
conv_data  in  16  conversion result.
m_axis_tdata  out  16  result sample.
m_axis_tuser  out  CH_W  channel of the sample.
m_axis_tlast  out  1  high on the last enabled channel of a scan.
m_axis_tvalid  out  1  stream valid.
m_axis_tready  in  1  stream ready.
drop_count  out  8  results lost because the FIFO was full; saturating.
skip_count  out  8  ticks that arrived while a scan was still active; saturating.
timeout_flag  out  1  sticky; set on any conversion timeout.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; period counter 0; FIFO empty; both counters 0; timeout_flag 0.
- Period counter:
  - Runs only while enable=1; cleared while enable=0.
  - Tick pulses when the counter equals eff_period-1, then the counter wraps to 0.
  - eff_period = max(sample_period, 2), compared live each cycle.
  - First tick occurs eff_period cycles after enable rises.
- FSM states: IDLE, SCAN_SEL, START, WAIT_DONE, NEXT.
  - IDLE: on tick with ch_mask != 0, latch ch_mask into scan_mask and go to SCAN_SEL. A tick with ch_mask == 0 is ignored and not counted.
  - SCAN_SEL: select the lowest set bit of scan_mask as cur_ch; go to START.
  - START: conv_start=1 for exactly one cycle with conv_ch=cur_ch; clear the timeout counter; go to WAIT_DONE.
  - WAIT_DONE: on conv_done, push {cur_ch, last, conv_data} to the FIFO and go to NEXT. last=1 when cur_ch is the highest set bit of scan_mask. If the timeout counter reaches TIMEOUT-1 first, set timeout_flag, push nothing, and go to NEXT. conv_done received in any other state is ignored.
  - NEXT: clear bit cur_ch in scan_mask. If scan_mask becomes 0 or enable=0, go to IDLE; otherwise go to SCAN_SEL.
- Latency: tick cycle T gives conv_start at T+2. A conv_done at cycle D gives m_axis_tvalid=1 at D+1 when the FIFO was empty.
- Skipped ticks: a tick that occurs while the FSM is not in IDLE increments skip_count, saturating at 255. No queued scan results from it.
- FIFO:
  - Push occurs on the accepted conv_done; pop occurs when m_axis_tvalid && m_axis_tready.
  - Push when full with no simultaneous pop: the entry is dropped and drop_count increments, saturating at 255.
  - Push when full with a simultaneous pop: the push is accepted and nothing is dropped.
  - Pop when empty: not possible, since tvalid=0.
  - Pointers are CLOG2(FIFO_DEPTH)+1 bits and wrap naturally.
- AXIS: tdata, tuser and tlast come from the FIFO head. They are stable while tvalid=1 and tready=0. tvalid never drops without a handshake, except on reset.
- Enable deasserted mid-scan: the in-flight conversion completes or times out and its result is pushed. The scan then ends with no further conv_start. The FIFO keeps draining.
- ch_mask changed mid-scan: takes effect at the next scan.
- Reset mid-operation: FIFO contents are discarded; conv_start stays 0. The reader core is expected to be reset in the same cycle.

Test Plan:
- NUM_CH=4, ch_mask=4'b1011, sample_period=100, reader responds 20 cycles after conv_start with data 16'hA000+ch, tready=1 -> per scan, samples A000/A001/A003 with tuser 0/1/3 and tlast only on ch3; scans 100 cycles apart; skip_count=0.
- sample_period=30 with a 20-cycle reader and 3 enabled channels -> every tick during a scan increments skip_count; the stream carries only complete scans.
- tready=0 for 3 full scans of 3 channels with FIFO_DEPTH=4 -> 4 entries held, drop_count=5; release tready -> first 4 samples emerge in order.
- Reader never asserts conv_done for ch1 of mask 4'b0011 -> timeout_flag=1 after TIMEOUT cycles, ch0 sample only, and conv_start for the next scan still occurs.
- Deassert enable during WAIT_DONE of ch0 in a 4-channel scan -> one sample output, no further conv_start; ch_mask=0 with enable=1 -> no conv_start and skip_count stays 0.
- Assert reset while the FIFO holds 2 entries and the FSM is in WAIT_DONE -> the next cycle shows tvalid=0, conv_start=0 and counters 0; a new scan starts eff_period cycles after reset is released with enable=1.
